traffic_phase_timer: RTL and testbench

//  Upstream timing stage for the cyclic traffic lamp sequencer. Divides clk into a tick,

---
 rtl/traffic_pkg.sv | 21 ++
 rtl/traffic_phase_timer_tick_prescaler.sv | 27 ++
 rtl/traffic_phase_timer.sv | 112 +++++++++++
 tb/tb_traffic_phase_timer.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/traffic_pkg.sv
// Shared phase codes, lamp encodings and dwell helpers for the traffic lamp sequencer.
package traffic_pkg;

    localparam int PHASE_W = 2;

    typedef enum logic [PHASE_W-1:0] {
        PH_RED    = 2'd0,
        PH_GREEN  = 2'd1,
        PH_YELLOW = 2'd2
    } phase_t;

    // One-hot lamp drive patterns consumed by the downstream lamp stage.
    localparam logic [2:0] RED    = 3'b100;
    localparam logic [2:0] GREEN  = 3'b010;
    localparam logic [2:0] YELLOW = 3'b001;

    function automatic int clamp_min1(input int t);
        return (t < 1) ? 1 : t;
    endfunction

endpackage

// File: rtl/traffic_phase_timer_tick_prescaler.sv
// Divides clk into a single-cycle tick every PRESCALE enabled cycles; frozen while enable=0.
module tick_prescaler #(
    parameter int PRESCALE = 10
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    output logic tick
);

    localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

    logic [CW-1:0] count;

    assign tick = enable && (count == LAST);

    // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (enable) begin
            count <= (count == LAST) ? '0 : count + 1'b1;
        end
    end

endmodule

// File: rtl/traffic_phase_timer.sv
// Phase timer: dwell counter + red/green/yellow FSM issuing a one-cycle advance strobe.
// Optional pedestrian request shortening of green is built when PED_REQ_EN is defined.
module traffic_phase_timer
    import traffic_pkg::*;
#(
    parameter int PRESCALE      = 10,
    parameter int CNT_W         = 8,
    parameter int RED_TIME      = 8,
    parameter int GREEN_TIME    = 6,
    parameter int YELLOW_TIME   = 2,
    parameter int PED_MIN_GREEN = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
`ifdef PED_REQ_EN
    input  logic             ped_req,
    output logic             ped_ack,
`endif
    output logic             advance,
    output logic [1:0]       phase,
    output logic [CNT_W-1:0] remaining
);

    localparam logic [CNT_W-1:0] RED_LD       = CNT_W'(clamp_min1(RED_TIME));
    localparam logic [CNT_W-1:0] GREEN_LD     = CNT_W'(clamp_min1(GREEN_TIME));
    localparam logic [CNT_W-1:0] YELLOW_LD    = CNT_W'(clamp_min1(YELLOW_TIME));
    localparam logic [CNT_W-1:0] PED_LD       = CNT_W'(clamp_min1(PED_MIN_GREEN));
    localparam logic [CNT_W-1:0] GREEN_PED_LD = (GREEN_LD < PED_LD) ? GREEN_LD : PED_LD;

    phase_t           phase_q;
    logic             tick;
    logic             pending;
    logic             phase_legal;
    logic             boundary;
    logic             red_entry;
    logic             shorten;
    logic [CNT_W-1:0] green_entry_ld;

    tick_prescaler #(
        .PRESCALE(PRESCALE)
    ) u_prescaler (
        .clk   (clk),
        .rst   (rst),
        .enable(enable),
        .tick  (tick)
    );

    assign phase = phase_q;

    // A corrupted phase code is treated as an immediate boundary back to red.
    assign phase_legal    = (phase_q == PH_RED) || (phase_q == PH_GREEN) || (phase_q == PH_YELLOW);
    assign boundary       = (remaining <= CNT_W'(1)) || !phase_legal;
    assign red_entry      = tick && boundary && (phase_q == PH_YELLOW);
    assign shorten        = pending && (phase_q == PH_GREEN) && (remaining > PED_LD);
    assign green_entry_ld = pending ? GREEN_PED_LD : GREEN_LD;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase_q   <= PH_RED;
            remaining <= RED_LD;
            advance   <= 1'b0;
        end else begin
            advance <= 1'b0;
            if (tick) begin
                if (boundary) begin
                    advance <= 1'b1;
                    case (phase_q)
                        PH_RED: begin
                            phase_q   <= PH_GREEN;
                            remaining <= green_entry_ld;
                        end
                        PH_GREEN: begin
                            phase_q   <= PH_YELLOW;
                            remaining <= YELLOW_LD;
                        end
                        default: begin
                            phase_q   <= PH_RED;
                            remaining <= RED_LD;
                        end
                    endcase
                end else if (shorten) begin
                    remaining <= PED_LD;
                end else begin
                    remaining <= remaining - 1'b1;
                end
            end
        end
    end

`ifdef PED_REQ_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending <= 1'b0;
            ped_ack <= 1'b0;
        end else begin
            ped_ack <= 1'b0;
            if (red_entry && pending) begin
                ped_ack <= 1'b1;
                pending <= 1'b0;
            end
            // Placed last so a request coinciding with the clear keeps pending set.
            if (ped_req) begin
                pending <= 1'b1;
            end
        end
    end
`else
    assign pending = 1'b0;
`endif

endmodule

// File: tb/tb_traffic_phase_timer.sv
// Self-checking bench for traffic_phase_timer: reset table, freeze/resume, ped and async reset
// sequences, then randomized stimulus against a dwell-list reference model.
module tb_traffic_phase_timer;

    localparam int P      = 2;
    localparam int CNT_W  = 8;
    localparam int T_RED  = 3;
    localparam int T_GRN  = 4;
    localparam int T_YEL  = 1;
    localparam int T_MIN  = 2;
`ifdef PED_REQ_EN
    localparam bit PED = 1'b1;
`else
    localparam bit PED = 1'b0;
`endif

    logic             clk;
    logic             rst;
    logic             enable;
    logic             advance;
    logic [1:0]       phase;
    logic [CNT_W-1:0] remaining;
`ifdef PED_REQ_EN
    logic             ped_req;
    logic             ped_ack;
`endif

    traffic_phase_timer #(
        .PRESCALE     (P),
        .CNT_W        (CNT_W),
        .RED_TIME     (T_RED),
        .GREEN_TIME   (T_GRN),
        .YELLOW_TIME  (T_YEL),
        .PED_MIN_GREEN(T_MIN)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .enable   (enable),
`ifdef PED_REQ_EN
        .ped_req  (ped_req),
        .ped_ack  (ped_ack),
`endif
        .advance  (advance),
        .phase    (phase),
        .remaining(remaining)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Reference model: dwell list per phase, tick every P-th enabled cycle.
    int dwell[3] = '{T_RED, T_GRN, T_YEL};
    int m_phase, m_rem, m_en_cycles;
    bit m_pend, m_adv, m_ack;

    function automatic int load_of(input int ph, input bit pend);
        int d = (dwell[ph] < 1) ? 1 : dwell[ph];
        if (ph == 1 && pend && d > T_MIN) d = T_MIN;
        return d;
    endfunction

    task automatic model_reset();
        m_phase = 0; m_rem = load_of(0, 1'b0); m_en_cycles = 0;
        m_pend = 1'b0; m_adv = 1'b0; m_ack = 1'b0;
    endtask

    task automatic model_step(input bit en, input bit req);
        bit tick;
        bit pend_old = m_pend;
        m_adv = 1'b0;
        m_ack = 1'b0;
        tick = en && ((m_en_cycles % P) == P - 1);
        if (en) m_en_cycles++;
        if (tick) begin
            if (m_rem <= 1) begin
                m_phase = (m_phase + 1) % 3;
                m_adv   = 1'b1;
                m_rem   = load_of(m_phase, pend_old);
                if (PED && m_phase == 0 && pend_old) begin
                    m_ack  = 1'b1;
                    m_pend = 1'b0;
                end
            end else if (PED && m_phase == 1 && pend_old && m_rem > T_MIN) begin
                m_rem = T_MIN;
            end else begin
                m_rem--;
            end
        end
        if (PED && req) m_pend = 1'b1;
    endtask

    task automatic step(input bit en, input bit req, input string tag);
        enable = en;
`ifdef PED_REQ_EN
        ped_req = req;
`endif
        @(posedge clk);
        model_step(en, req);
        @(negedge clk);
        check({tag, " phase"},     int'(phase),     m_phase);
        check({tag, " remaining"}, int'(remaining), m_rem);
        check({tag, " advance"},   int'(advance),   int'(m_adv));
`ifdef PED_REQ_EN
        check({tag, " ped_ack"},   int'(ped_ack),   int'(m_ack));
`endif
    endtask

    task automatic do_reset();
        rst    = 1'b1;
        enable = 1'b0;
`ifdef PED_REQ_EN
        ped_req = 1'b0;
`endif
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    typedef struct {
        bit en;
        bit adv;
        int ph;
        int rem;
    } vec_t;

    vec_t tbl[16];

    initial begin
        int n, green_cycles, ack_cycles, ack_at;
        bit found;

        tbl = '{'{1, 0, 0, 3}, '{1, 0, 0, 2}, '{1, 0, 0, 2}, '{1, 0, 0, 1},
                '{1, 0, 0, 1}, '{1, 1, 1, 4}, '{1, 0, 1, 4}, '{1, 0, 1, 3},
                '{1, 0, 1, 3}, '{1, 0, 1, 2}, '{1, 0, 1, 2}, '{1, 0, 1, 1},
                '{1, 0, 1, 1}, '{1, 1, 2, 1}, '{1, 0, 2, 1}, '{1, 1, 0, 3}};

        // Reset state and the first full red -> green -> yellow -> red cycle.
        do_reset();
        check("reset phase", int'(phase), 0);
        check("reset remaining", int'(remaining), T_RED);
        check("reset advance", int'(advance), 0);
        foreach (tbl[i]) begin
            step(tbl[i].en, 1'b0, $sformatf("tbl[%0d]", i));
            check($sformatf("tbl[%0d] exp advance", i), int'(advance), int'(tbl[i].adv));
            check($sformatf("tbl[%0d] exp phase", i), int'(phase), tbl[i].ph);
            check($sformatf("tbl[%0d] exp remaining", i), int'(remaining), tbl[i].rem);
        end

        // Freeze mid-green for 10 cycles; the boundary slips exactly 10 cycles.
        do_reset();
        for (int k = 1; k <= 9; k++) step(1'b1, 1'b0, $sformatf("pre-freeze c%0d", k));
        for (int k = 0; k < 10; k++) begin
            step(1'b0, 1'b0, $sformatf("freeze %0d", k));
            check("freeze phase held", int'(phase), 1);
            check("freeze remaining held", int'(remaining), 3);
            check("freeze no advance", int'(advance), 0);
        end
        n = 0;
        found = 1'b0;
        while (!found && n < 40) begin
            n++;
            step(1'b1, 1'b0, $sformatf("resume %0d", n));
            found = advance;
        end
        check("resume boundary found", int'(found), 1);
        check("resume boundary cycle", 19 + n, 24);

`ifdef PED_REQ_EN
        // Pulse during red: green shortened to 2 ticks, ack on entry to red.
        do_reset();
        green_cycles = 0; ack_cycles = 0; ack_at = 0;
        for (int k = 1; k <= 14; k++) begin
            step(1'b1, k == 1, $sformatf("ped1 c%0d", k));
            if (phase == 2'd1) green_cycles++;
            if (ped_ack) begin ack_cycles++; ack_at = k; end
        end
        check("ped1 green cycles", green_cycles, 4);
        check("ped1 ack pulses", ack_cycles, 1);
        check("ped1 ack cycle", ack_at, 12);

        // Request in green cuts remaining to 2; held through ack keeps it pending.
        do_reset();
        for (int k = 1; k <= 6; k++) step(1'b1, 1'b0, $sformatf("ped2 c%0d", k));
        step(1'b1, 1'b1, "ped2 c7");
        check("ped2 no tick yet", int'(remaining), 4);
        step(1'b1, 1'b1, "ped2 c8");
        check("ped2 shortened", int'(remaining), 2);
        green_cycles = 0; ack_cycles = 0; ack_at = 0;
        for (int k = 9; k <= 30; k++) begin
            step(1'b1, k <= 14, $sformatf("ped2 c%0d", k));
            if (k >= 15 && phase == 2'd1) green_cycles++;
            if (ped_ack) begin
                ack_cycles++;
                if (ack_at == 0) ack_at = k;
            end
            if (k == 20) check("ped2 second green load", int'(remaining), 2);
        end
        check("ped2 first ack cycle", ack_at, 14);
        check("ped2 ack pulses", ack_cycles, 2);
        check("ped2 second green cycles", green_cycles, 4);
`endif

        // Async reset between edges while in yellow with advance high.
        do_reset();
        for (int k = 1; k <= 14; k++) step(1'b1, 1'b0, $sformatf("pre-rst c%0d", k));
        check("pre-rst in yellow", int'(phase), 2);
        #1 rst = 1'b1;
        #1;
        check("async rst phase", int'(phase), 0);
        check("async rst remaining", int'(remaining), T_RED);
        check("async rst advance", int'(advance), 0);
`ifdef PED_REQ_EN
        check("async rst ped_ack", int'(ped_ack), 0);
`endif
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        for (int k = 1; k <= 6; k++) step(1'b1, 1'b0, $sformatf("post-rst c%0d", k));

        // Randomized enable / request traffic against the model.
        do_reset();
        for (int k = 0; k < 3000; k++) begin
            step(($urandom % 8) != 0, ($urandom % 16) == 0, $sformatf("rand %0d", k));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

endmodule
